// File: rtl/whack_game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : whack_game_controller
//  Description : Single-clock whack-a-mole game flow. Handles the pre-game
//                countdown, timed play with a level-selectable mole rate,
//                LFSR mole placement, hit/miss scoring and a high-score
//                register. Drives the score/time display chain and LED bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module whack_game_controller #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned NUM_MOLES   = 16,
    parameter int unsigned NUM_LEVELS  = 3,
    parameter int unsigned LVL_W       = 2,
    parameter int unsigned COUNTDOWN_S = 3,
    parameter int unsigned GAME_S      = 30,
    parameter int unsigned SCORE_W     = 16,
    parameter bit          PENALTY_EN  = 1'b1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [LVL_W-1:0]     level_i,
    input  logic [NUM_MOLES-1:0] switches_i,
    output logic [1:0]           state_o,
    output logic [LVL_W-1:0]     level_o,
    output logic [7:0]           time_o,
    output logic [NUM_MOLES-1:0] moles_o,
    output logic [SCORE_W-1:0]   score_o,
    output logic [SCORE_W-1:0]   high_score_o
);

    localparam int unsigned        IDX_W     = $clog2(NUM_MOLES);
    localparam int unsigned        CNT_W     = $clog2(CLK_HZ + 1);
    localparam logic [CNT_W-1:0]   SEC_LAST  = CNT_W'(CLK_HZ - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [7:0]         CD_INIT   = 8'(COUNTDOWN_S);
    localparam logic [7:0]         GAME_INIT = 8'(GAME_S);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_COUNTDOWN = 2'b01,
        ST_PLAY      = 2'b10,
        ST_DONE      = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [7:0]           time_q, time_d;
    logic [NUM_MOLES-1:0] moles_q, moles_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   high_q, high_d;
    logic [CNT_W-1:0]     sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0]     mole_cnt_q, mole_cnt_d;
    logic [15:0]          lfsr_q;

    logic                 start_cur_q, start_prev_q;
    logic [NUM_MOLES-1:0] sw_s1_q, sw_s2_q, sw_prev_q;

    logic                 start_edge;
    logic                 level_ok;
    logic                 sec_tick;
    logic [31:0]          mole_period;
    logic [CNT_W-1:0]     mole_last;
    logic                 mole_wrap;
    logic [IDX_W-1:0]     place_idx;
    logic [NUM_MOLES-1:0] place_vec;
    logic [NUM_MOLES-1:0] toggles;
    logic                 hit, miss;
    logic [SCORE_W-1:0]   score_adj;

    assign start_edge = start_cur_q & ~start_prev_q;
    assign level_ok   = (level_i != '0) && (32'(level_i) <= NUM_LEVELS);
    assign sec_tick   = (sec_cnt_q == SEC_LAST);

    // Each level halves the mole period; level is at least 1 whenever PLAY is active.
    assign mole_period = CLK_HZ >> (level_q - LVL_W'(1));
    assign mole_last   = (mole_period == 32'd0) ? '0 : CNT_W'(mole_period - 32'd1);
    assign mole_wrap   = (mole_cnt_q == mole_last);

    assign toggles = sw_s2_q ^ sw_prev_q;
    assign hit     = |(toggles & moles_q);
    assign miss    = |(toggles & ~moles_q);

    // Pick the next mole from the LFSR, stepping past the currently lit one.
    always_comb begin
        place_idx = lfsr_q[IDX_W-1:0];
        if (moles_q[place_idx]) begin
            place_idx = place_idx + IDX_W'(1);
        end
        place_vec = {{(NUM_MOLES-1){1'b0}}, 1'b1} << place_idx;
    end

    // Saturating score adjustment; a hit and a penalised miss cancel out.
    always_comb begin
        score_adj = score_q;
        if (hit && !(miss && PENALTY_EN)) begin
            score_adj = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
        end else if (miss && PENALTY_EN && !hit) begin
            score_adj = (score_q == '0) ? score_q : score_q - SCORE_W'(1);
        end
    end

    // Input conditioning: start edge detect and two-stage switch synchroniser.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            start_cur_q  <= 1'b0;
            start_prev_q <= 1'b0;
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            sw_prev_q    <= '0;
        end else begin
            start_cur_q  <= start_i;
            start_prev_q <= start_cur_q;
            sw_s1_q      <= switches_i;
            sw_s2_q      <= sw_s1_q;
            sw_prev_q    <= sw_s2_q;
        end
    end

    // Free-running LFSR (taps 16,14,13,11), stepping every cycle in every state.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Game state and output registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            time_q     <= '0;
            moles_q    <= '0;
            score_q    <= '0;
            high_q     <= '0;
            sec_cnt_q  <= '0;
            mole_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            time_q     <= time_d;
            moles_q    <= moles_d;
            score_q    <= score_d;
            high_q     <= high_d;
            sec_cnt_q  <= sec_cnt_d;
            mole_cnt_q <= mole_cnt_d;
        end
    end

    // Next-state logic: start handling, countdown, play timing, moles and scoring.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        time_d     = time_q;
        moles_d    = moles_q;
        score_d    = score_q;
        high_d     = high_q;
        sec_cnt_d  = sec_cnt_q;
        mole_cnt_d = mole_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                sec_cnt_d  = '0;
                mole_cnt_d = '0;
                if (start_edge && level_ok) begin
                    state_d = ST_COUNTDOWN;
                    level_d = level_i;
                    time_d  = CD_INIT;
                    score_d = '0;
                    moles_d = '0;
                end
            end

            ST_COUNTDOWN: begin
                sec_cnt_d = sec_tick ? '0 : sec_cnt_q + CNT_W'(1);
                if (sec_tick) begin
                    if (time_q > 8'd1) begin
                        time_d = time_q - 8'd1;
                    end else begin
                        state_d    = ST_PLAY;
                        time_d     = GAME_INIT;
                        moles_d    = place_vec;
                        mole_cnt_d = '0;
                    end
                end
            end

            ST_PLAY: begin
                sec_cnt_d  = sec_tick ? '0 : sec_cnt_q + CNT_W'(1);
                mole_cnt_d = mole_wrap ? '0 : mole_cnt_q + CNT_W'(1);
                score_d    = score_adj;
                if (hit) begin
                    moles_d = '0;
                end
                // A placement overrides the hit clear; game end overrides both.
                if (mole_wrap) begin
                    moles_d = place_vec;
                end
                if (sec_tick) begin
                    if (time_q > 8'd1) begin
                        time_d = time_q - 8'd1;
                    end else begin
                        state_d = ST_DONE;
                        time_d  = '0;
                        moles_d = '0;
                        high_d  = (score_adj > high_q) ? score_adj : high_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state_o      = state_q;
    assign level_o      = level_q;
    assign time_o       = time_q;
    assign moles_o      = moles_q;
    assign score_o      = score_q;
    assign high_score_o = high_q;

endmodule
`default_nettype wire
